// File: rtl/alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_arbiter : two requesters share one combinational 64-bit ALU, each    |
// |               with its own single-entry response register.               |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+

module alu_arbiter_alu (
    input  logic [1:0]  op,
    input  logic [63:0] arg1,
    input  logic [63:0] arg2,
    output logic [63:0] result
);
    localparam logic [1:0] c_op_and = 2'b00;
    localparam logic [1:0] c_op_or  = 2'b01;
    localparam logic [1:0] c_op_add = 2'b10;
    localparam logic [1:0] c_op_sub = 2'b11;

    always_comb begin
        result = '0;
        case (op)
            c_op_and: result = arg1 & arg2;
            c_op_or:  result = arg1 | arg2;
            c_op_add: result = arg1 + arg2;
            c_op_sub: result = arg1 - arg2;
            default:  result = '0;
        endcase
    end
endmodule

module alu_arbiter_slot (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        accept,
    input  logic        drain,
    input  logic [63:0] load_data,
    output logic        valid,
    output logic [63:0] result
);
    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

    logic [0:0]  r_state;
    logic [63:0] r_result;

    // Arbitration only accepts into a FULL slot when it is being drained,
    // so a FULL accept is always a replace; the result persists after drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_st_empty;
            r_result <= '0;
        end else begin
            case (r_state)
                c_st_empty: begin
                    if (accept) begin
                        r_state  <= c_st_full;
                        r_result <= load_data;
                    end
                end
                c_st_full: begin
                    if (accept) begin
                        r_result <= load_data;
                    end else if (drain) begin
                        r_state <= c_st_empty;
                    end
                end
                default: r_state <= c_st_empty;
            endcase
        end
    end

    assign valid  = (r_state == c_st_full);
    assign result = r_result;
endmodule

module alu_arbiter #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [63:0] req0_arg1,
    input  logic [63:0] req0_arg2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [63:0] req1_arg1,
    input  logic [63:0] req1_arg2,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [63:0] rsp0_result,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] rsp1_result
);
    logic [1:0]       w_req_valid;
    logic [1:0]       w_rsp_ready;
    logic [1:0]       w_rsp_valid;
    logic [1:0][63:0] w_rsp_result;
    logic [1:0]       w_elig;
    logic [1:0]       w_grant;
    logic             w_sel;
    logic [1:0]       w_op;
    logic [63:0]      w_arg1;
    logic [63:0]      w_arg2;
    logic [63:0]      w_alu_result;
    logic             r_prio;

    assign w_req_valid = {req1_valid, req0_valid};
    assign w_rsp_ready = {rsp1_ready, rsp0_ready};

    // A requester may issue if its slot is empty or is being drained now;
    // gating with rst_n keeps both readies low throughout reset.
    assign w_elig = w_req_valid & (~w_rsp_valid | w_rsp_ready) & {2{rst_n}};

    always_comb begin
        w_grant = 2'b00;
        case (w_elig)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_prio ? 2'b10 : 2'b01;
            default: w_grant = 2'b00;
        endcase
    end

    assign w_sel      = w_grant[1];
    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    assign w_op   = w_sel ? req1_op   : req0_op;
    assign w_arg1 = w_sel ? req1_arg1 : req0_arg1;
    assign w_arg2 = w_sel ? req1_arg2 : req0_arg2;

    alu_arbiter_alu u_alu (
        .op     (w_op),
        .arg1   (w_arg1),
        .arg2   (w_arg2),
        .result (w_alu_result)
    );

    // Priority moves to the requester that was not just served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio <= PRIO_INIT;
        end else if (|w_grant) begin
            r_prio <= w_grant[0];
        end
    end

    generate
        for (genvar i = 0; i < 2; i++) begin : g_slot
            alu_arbiter_slot u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .accept    (w_grant[i]),
                .drain     (w_rsp_ready[i]),
                .load_data (w_alu_result),
                .valid     (w_rsp_valid[i]),
                .result    (w_rsp_result[i])
            );
        end
    endgenerate

    assign rsp0_valid  = w_rsp_valid[0];
    assign rsp1_valid  = w_rsp_valid[1];
    assign rsp0_result = w_rsp_result[0];
    assign rsp1_result = w_rsp_result[1];
endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_arbiter : directed + random stimulus against a behavioural model. |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
    logic [63:0] req0_arg1 = '0, req0_arg2 = '0, req1_arg1 = '0, req1_arg2 = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [63:0] rsp0_result, rsp1_result;

    int n_chk  = 0;
    int n_fail = 0;

    alu_arbiter #(.PRIO_INIT(1'b0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_op     (req0_op),
        .req0_arg1   (req0_arg1),
        .req0_arg2   (req0_arg2),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_op     (req1_op),
        .req1_arg1   (req1_arg1),
        .req1_arg2   (req1_arg2),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_result (rsp0_result),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_result (rsp1_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: slot occupancy, stored results, priority holder.
    logic [1:0]  m_valid = 2'b00;
    logic [63:0] m_result [2];
    logic        m_prio = 1'b0;
    initial begin
        m_result[0] = '0;
        m_result[1] = '0;
    end

    function automatic logic [63:0] alu_ref(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a + b;
            default: return a - b;
        endcase
    endfunction

    function automatic bit gnt(input int i);
        bit e0, e1;
        int winner;
        e0 = rst_n && req0_valid && (!m_valid[0] || rsp0_ready);
        e1 = rst_n && req1_valid && (!m_valid[1] || rsp1_ready);
        winner = -1;
        if (e0 && e1)  winner = m_prio ? 1 : 0;
        else if (e0)   winner = 0;
        else if (e1)   winner = 1;
        return winner == i;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid     <= 2'b00;
            m_result[0] <= '0;
            m_result[1] <= '0;
            m_prio      <= 1'b0;
        end else begin
            if (gnt(0)) begin
                m_valid[0]  <= 1'b1;
                m_result[0] <= alu_ref(req0_op, req0_arg1, req0_arg2);
            end else if (rsp0_ready) begin
                m_valid[0] <= 1'b0;
            end
            if (gnt(1)) begin
                m_valid[1]  <= 1'b1;
                m_result[1] <= alu_ref(req1_op, req1_arg1, req1_arg2);
            end else if (rsp1_ready) begin
                m_valid[1] <= 1'b0;
            end
            if (gnt(0))      m_prio <= 1'b1;
            else if (gnt(1)) m_prio <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("model req0_ready",  req0_ready,  gnt(0));
        chk("model req1_ready",  req1_ready,  gnt(1));
        chk("model rsp0_valid",  rsp0_valid,  m_valid[0]);
        chk("model rsp1_valid",  rsp1_valid,  m_valid[1]);
        chk("model rsp0_result", rsp0_result, m_result[0]);
        chk("model rsp1_result", rsp1_result, m_result[1]);
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return '0;
            2:       return 64'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        // Reset state
        nxt();
        smp();
        chk("reset rsp0_valid", rsp0_valid, 0);
        chk("reset rsp1_valid", rsp1_valid, 0);
        chk("reset rsp0_result", rsp0_result, 0);
        chk("reset req0_ready", req0_ready, 0);

        // Single ADD, first grant in first cycle out of reset
        nxt();
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_op = 2'd2; req0_arg1 = 64'd5; req0_arg2 = 64'd7;
        rsp0_ready = 1'b1;
        smp(); chk("single ready T", req0_ready, 1);
        nxt(); req0_valid = 1'b0;
        smp(); chk("single valid T+1", rsp0_valid, 1);
        chk("single result", rsp0_result, 64'd12);
        nxt();
        smp(); chk("single valid T+2", rsp0_valid, 0);
        chk("single result retained", rsp0_result, 64'd12);

        // Wrap-around on requester 1
        nxt();
        req1_valid = 1'b1; req1_op = 2'd3; req1_arg1 = 64'd0; req1_arg2 = 64'd1;
        rsp1_ready = 1'b1;
        smp(); chk("wrap sub ready", req1_ready, 1);
        nxt();
        req1_op = 2'd2; req1_arg1 = '1; req1_arg2 = 64'd1;
        smp(); chk("wrap sub result", rsp1_result, 64'hFFFF_FFFF_FFFF_FFFF);
        nxt(); req1_valid = 1'b0;
        smp(); chk("wrap add result", rsp1_result, 64'd0);

        // Contention, alternating grants
        nxt();
        req0_valid = 1'b1; req0_op = 2'd0; req0_arg1 = 64'hF0; req0_arg2 = 64'h3C;
        req1_valid = 1'b1; req1_op = 2'd1; req1_arg1 = 64'hF0; req1_arg2 = 64'h0F;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("contend req0_ready", req0_ready, (k % 2 == 0) ? 1 : 0);
            chk("contend req1_ready", req1_ready, (k % 2 == 1) ? 1 : 0);
            nxt();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        smp();
        chk("contend rsp0_result", rsp0_result, 64'h30);
        chk("contend rsp1_result", rsp1_result, 64'hFF);

        // Backpressure on requester 0 does not block requester 1
        nxt();
        req0_valid = 1'b1; req0_op = 2'd0; req0_arg1 = 64'hAA; req0_arg2 = 64'hFF;
        rsp0_ready = 1'b0;
        smp(); chk("bp fill ready", req0_ready, 1);
        nxt();
        req0_op = 2'd2; req0_arg1 = 64'd1; req0_arg2 = 64'd1;
        req1_valid = 1'b1; req1_op = 2'd2; req1_arg1 = 64'd3; req1_arg2 = 64'd4;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("bp req0_ready", req0_ready, 0);
            chk("bp req1_ready", req1_ready, 1);
            chk("bp rsp0_result stable", rsp0_result, 64'hAA);
            nxt();
        end
        rsp0_ready = 1'b1;
        smp(); chk("bp release req0_ready", req0_ready, 1);
        chk("bp release req1_ready", req1_ready, 0);
        nxt(); req0_valid = 1'b0; req1_valid = 1'b0;
        smp(); chk("bp new result", rsp0_result, 64'd2);
        chk("bp rsp1 result", rsp1_result, 64'd7);

        // Back-to-back throughput
        nxt();
        req0_valid = 1'b1; req0_op = 2'd2; req0_arg1 = 64'd1;
        for (int k = 0; k < 5; k++) begin
            req0_arg2 = 64'(k);
            smp(); chk("b2b ready", req0_ready, 1);
            if (k > 0) chk("b2b result", rsp0_result, 64'(k));
            nxt();
        end
        req0_valid = 1'b0;
        smp(); chk("b2b last result", rsp0_result, 64'd5);

        // Reset mid-operation
        nxt();
        req0_valid = 1'b1; req0_op = 2'd0; req0_arg1 = 64'h55; req0_arg2 = 64'h5F;
        nxt();
        rst_n = 1'b0;
        smp(); chk("rst mid req0_ready", req0_ready, 0);
        chk("rst mid rsp0_valid before", rsp0_valid, 1);
        nxt();
        rst_n = 1'b1;
        req1_valid = 1'b1; rsp1_ready = 1'b1;
        smp(); chk("rst mid rsp0_valid", rsp0_valid, 0);
        chk("rst mid rsp0_result", rsp0_result, 0);
        chk("rst mid prio grant", req0_ready, 1);
        nxt();
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Randomized traffic checked by the model
        for (int c = 0; c < 4000; c++) begin
            nxt();
            rst_n      = ($urandom_range(0, 99) != 0);
            req0_valid = ($urandom_range(0, 9) < 7);
            req1_valid = ($urandom_range(0, 9) < 7);
            rsp0_ready = ($urandom_range(0, 9) < 6);
            rsp1_ready = ($urandom_range(0, 9) < 6);
            req0_op    = 2'($urandom_range(0, 3));
            req1_op    = 2'($urandom_range(0, 3));
            req0_arg1  = rnd64(); req0_arg2 = rnd64();
            req1_arg1  = rnd64(); req1_arg2 = rnd64();
        end
        nxt();
        rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) nxt();
        smp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
